pipe_datapath: RTL and testbench
================================

PIPE_DATAPATH -- requirements
Module: pipe_datapath

Interface
REQ-001 Parameter: DATA_W, 16, operand/result/register width in bits (legal 8..64).
REQ-002 Parameter: REG_CNT, 8, number of architectural registers, power of two, 4..32; RA_W = log2(REG_CNT).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  instruction presented this cycle.
REQ-006 in_ready  output  1  instruction accepted when in_valid & in_ready at rising edge.
REQ-007 op  input  3  ALU control: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; other codes give result 0.
REQ-008 rs, rt, rd  input  RA_W each  source A, source B, destination register addresses.
REQ-009 imm  input  DATA_W  immediate operand.
REQ-010 use_imm  input  1  1: operand B = imm; 0: operand B = R[rt].
REQ-011 reg_write  input  1  instruction writes rd.
REQ-012 stall  input  1  freeze entire pipeline.
REQ-013 flush  input  1  discard all in-flight instructions.
REQ-014 wb_valid  output  1  writeback-stage instruction valid.
REQ-015 wb_addr  output  RA_W  writeback destination.
REQ-016 wb_data  output  DATA_W  writeback result.
REQ-017 wb_zero  output  1  wb_data == 0.
REQ-018 dbg_addr  input  RA_W / dbg_data  output  DATA_W  combinational register-file read port.
REQ-019 retired_cnt  output  16  count of completed instructions.

Function
REQ-020 Pipeline SHALL have three stages: read/accept, EX register (op, A, B, rd, we, valid), WB register (wb_* , we, valid).
REQ-021 in_ready SHALL equal !stall.
REQ-022 On accept edge, EX register SHALL capture operands; next unstalled edge WB register SHALL capture ALU result; wb_valid SHALL assert exactly 2 unstalled edges after accept.
REQ-023 Register file SHALL be written from WB register at the edge ending a cycle with wb_valid & we & wb_addr != 0 & !stall & !flush.
REQ-024 Register 0 SHALL read as 0 always; writes to it discarded and never forwarded.
REQ-025 Operand read priority per source: EX-stage match (valid, we, rd == src, src != 0) -> live ALU result; else WB-stage match -> wb_data; else register file.
REQ-026 ADD/SUB SHALL wrap modulo 2^DATA_W; SLT SHALL be signed two's-complement, result 1 or 0 zero-extended.
REQ-027 stall=1 SHALL hold all pipeline registers, outputs, counter and register file unchanged; no instruction accepted.
REQ-028 flush=1 SHALL clear EX and WB valid bits at the edge, suppress that edge's RF write and accept, and override stall; register file retained.
REQ-029 Bubble cycles (no accept) SHALL propagate valid=0; wb_data and wb_addr hold last valid values.
REQ-030 retired_cnt SHALL increment by 1 at each edge where wb_valid & !stall & !flush, regardless of we; wraps 0xFFFF -> 0x0000.
REQ-031 dbg_data SHALL reflect the register file state only (no forwarding).

Reset
REQ-032 rst=0 SHALL immediately clear valid bits, wb_addr, wb_data, retired_cnt and all registers to 0; wb_zero=1, in_ready=!stall.
REQ-033 Instructions in flight when reset asserts SHALL be lost; no RF write occurs.
REQ-034 First accept permitted on first rising edge after rst deasserts.

Verification (DATA_W=16, REG_CNT=8)
REQ-035 Reset, ADD rd=1 rs=0 imm=5 use_imm -> wb_valid 2 edges later, wb_data=0x0005; next cycle dbg r1=0x0005, retired_cnt=1.
REQ-036 Back-to-back: r1=r0+5(imm); r2=r1+r1; r3=r2 SUB r1 -> wb_data 0x0005, 0x000A, 0x0005 on consecutive cycles (EX and WB forwarding).
REQ-037 r1=0xFFFF(imm); r2=r1 ADD 1(imm) -> 0x0000, wb_zero=1; r3=r1 SLT 1(imm) -> 0x0001.
REQ-038 ADD rd=0 imm=7 then r4=r0+r0 -> second wb_data=0x0000; dbg r0=0.
REQ-039 stall held 3 cycles while wb_valid=1 -> wb_data constant, exactly one RF write, retired_cnt +1 only; flush with two in flight -> no writes, count unchanged.
REQ-040 rst pulsed low mid-sequence with three in flight -> all outputs 0 asynchronously, dbg all registers 0.

Source files
------------

// File: rtl/pipe_datapath.sv
// Three-stage ALU datapath: operand read/accept, EX register, WB register.
// EX/WB forwarding feeds operand reads; the register file is written from WB.
module pipe_datapath #(
  parameter  int DATA_W  = 16,
  parameter  int REG_CNT = 8,
  localparam int RA_W    = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [RA_W-1:0]   rs,
  input  logic [RA_W-1:0]   rt,
  input  logic [RA_W-1:0]   rd,
  input  logic [DATA_W-1:0] imm,
  input  logic              use_imm,
  input  logic              reg_write,
  input  logic              stall,
  input  logic              flush,
  output logic              wb_valid,
  output logic [RA_W-1:0]   wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_zero,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       retired_cnt
);

  logic [DATA_W-1:0] r_regs [REG_CNT];

  logic              r_exValid;
  logic [2:0]        r_exOp;
  logic [DATA_W-1:0] r_exA;
  logic [DATA_W-1:0] r_exB;
  logic [RA_W-1:0]   r_exRd;
  logic              r_exWe;

  logic              r_wbValid;
  logic [RA_W-1:0]   r_wbAddr;
  logic [DATA_W-1:0] r_wbData;
  logic              r_wbWe;

  logic [15:0]       r_retired;

  logic [DATA_W-1:0] w_aluRes;
  logic              w_slt;
  logic [DATA_W-1:0] w_opA;
  logic [DATA_W-1:0] w_opB;
  logic [DATA_W-1:0] w_rtVal;

  assign in_ready    = !stall;
  assign wb_valid    = r_wbValid;
  assign wb_addr     = r_wbAddr;
  assign wb_data     = r_wbData;
  assign wb_zero     = (r_wbData == '0);
  assign retired_cnt = r_retired;
  assign dbg_data    = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];

  assign w_slt = ($signed(r_exA) < $signed(r_exB));

  always_comb begin
    w_aluRes = '0;
    case (r_exOp)
      3'b000:  w_aluRes = r_exA & r_exB;
      3'b001:  w_aluRes = r_exA | r_exB;
      3'b010:  w_aluRes = r_exA + r_exB;
      3'b110:  w_aluRes = r_exA - r_exB;
      3'b111:  w_aluRes = {{(DATA_W-1){1'b0}}, w_slt};
      default: w_aluRes = '0;
    endcase
  end

  // The younger EX result wins over WB; register 0 is never forwarded.
  always_comb begin
    w_opA = (rs == '0) ? '0 : r_regs[rs];
    if (rs != '0 && r_exValid && r_exWe && r_exRd == rs) begin
      w_opA = w_aluRes;
    end else if (rs != '0 && r_wbValid && r_wbWe && r_wbAddr == rs) begin
      w_opA = r_wbData;
    end
  end

  always_comb begin
    w_rtVal = (rt == '0) ? '0 : r_regs[rt];
    if (rt != '0 && r_exValid && r_exWe && r_exRd == rt) begin
      w_rtVal = w_aluRes;
    end else if (rt != '0 && r_wbValid && r_wbWe && r_wbAddr == rt) begin
      w_rtVal = r_wbData;
    end
  end

  assign w_opB = use_imm ? imm : w_rtVal;

  // Flush beats stall; bubbles leave wb_addr/wb_data at their last valid values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exValid <= 1'b0;
      r_exOp    <= '0;
      r_exA     <= '0;
      r_exB     <= '0;
      r_exRd    <= '0;
      r_exWe    <= 1'b0;
      r_wbValid <= 1'b0;
      r_wbAddr  <= '0;
      r_wbData  <= '0;
      r_wbWe    <= 1'b0;
      r_retired <= '0;
      for (int i = 0; i < REG_CNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (flush) begin
      r_exValid <= 1'b0;
      r_wbValid <= 1'b0;
    end else if (!stall) begin
      if (r_wbValid && r_wbWe && r_wbAddr != '0) begin
        r_regs[r_wbAddr] <= r_wbData;
      end
      if (r_wbValid) begin
        r_retired <= r_retired + 16'd1;
      end
      r_wbValid <= r_exValid;
      if (r_exValid) begin
        r_wbAddr <= r_exRd;
        r_wbData <= w_aluRes;
        r_wbWe   <= r_exWe;
      end
      r_exValid <= in_valid;
      if (in_valid) begin
        r_exOp <= op;
        r_exA  <= w_opA;
        r_exB  <= w_opB;
        r_exRd <= rd;
        r_exWe <= reg_write;
      end
    end
  end

endmodule

// File: tb/tb_pipe_datapath.sv
// Scoreboard bench for pipe_datapath: a sequential register model predicts each
// writeback, and the queue is popped whenever the WB stage presents a new result.
module tb_pipe_datapath;

  localparam int DATA_W  = 16;
  localparam int REG_CNT = 8;
  localparam int RA_W    = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op;
  logic [RA_W-1:0]   rs;
  logic [RA_W-1:0]   rt;
  logic [RA_W-1:0]   rd;
  logic [DATA_W-1:0] imm;
  logic              use_imm;
  logic              reg_write;
  logic              stall;
  logic              flush;
  logic              wb_valid;
  logic [RA_W-1:0]   wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_zero;
  logic [RA_W-1:0]   dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [15:0]       retired_cnt;

  typedef struct {
    logic [RA_W-1:0]   addr;
    logic [DATA_W-1:0] data;
  } sbEntry_t;

  sbEntry_t          sbQueue [$];
  logic [DATA_W-1:0] mRegs [REG_CNT];
  logic [DATA_W-1:0] savedRegs [REG_CNT];
  int                mRetired;
  int                savedRetired;
  logic [DATA_W-1:0] savedR5;
  int                checkCount = 0;
  int                failCount  = 0;
  logic              adv = 1'b0;

  pipe_datapath #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .use_imm(use_imm),
    .reg_write(reg_write), .stall(stall), .flush(flush),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_zero(wb_zero),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .retired_cnt(retired_cnt)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Presents one instruction at a falling edge and predicts its result in program order.
  task automatic applyStimulus(input int aOp, input int aRd, input int aRs, input int aRt,
                               input int aImm, input int aUseImm, input int aWe);
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] res;
    sbEntry_t          e;
    @(negedge clk);
    in_valid  = 1'b1;
    stall     = 1'b0;
    flush     = 1'b0;
    op        = 3'(aOp);
    rd        = RA_W'(aRd);
    rs        = RA_W'(aRs);
    rt        = RA_W'(aRt);
    imm       = DATA_W'(aImm);
    use_imm   = (aUseImm != 0);
    reg_write = (aWe != 0);
    a = (aRs == 0) ? '0 : mRegs[aRs];
    b = (aUseImm != 0) ? DATA_W'(aImm) : ((aRt == 0) ? '0 : mRegs[aRt]);
    case (3'(aOp))
      3'd0:    res = a & b;
      3'd1:    res = a | b;
      3'd2:    res = a + b;
      3'd6:    res = a - b;
      3'd7:    res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      default: res = '0;
    endcase
    e.addr = RA_W'(aRd);
    e.data = res;
    sbQueue.push_back(e);
    if (aWe != 0 && aRd != 0) mRegs[aRd] = res;
    mRetired++;
  endtask

  task automatic idleCycle(input logic aStall);
    @(negedge clk);
    in_valid = 1'b0;
    stall    = aStall;
    flush    = 1'b0;
  endtask

  task automatic drain();
    repeat (3) idleCycle(1'b0);
  endtask

  task automatic checkRegs(input string tag);
    for (int i = 0; i < REG_CNT; i++) begin
      dbg_addr = RA_W'(i);
      #1;
      checkOutput($sformatf("%s_r%0d", tag, i), dbg_data, mRegs[i]);
    end
  endtask

  always @(posedge clk) begin
    checkOutput("in_ready", in_ready, !stall);
    adv <= rst && !stall && !flush;
  end

  always @(negedge clk) begin
    if (wb_valid && adv) begin
      if (sbQueue.size() == 0) begin
        checkOutput("sb_underflow", 1, 0);
      end else begin
        sbEntry_t e;
        e = sbQueue.pop_front();
        checkOutput("wb_addr", wb_addr, e.addr);
        checkOutput("wb_data", wb_data, e.data);
        checkOutput("wb_zero", wb_zero, (e.data == '0));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ops [8] = '{0, 1, 2, 6, 7, 3, 4, 5};
    int rOp, rRd, rRs, rRt, rImm, rUse, rWe, gap;
    rst = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    op = '0; rs = '0; rt = '0; rd = '0; imm = '0; use_imm = 1'b0; reg_write = 1'b0;
    dbg_addr = '0;
    mRetired = 0;
    for (int i = 0; i < REG_CNT; i++) mRegs[i] = '0;
    #1;
    checkOutput("rst_wb_valid", wb_valid, 0);
    checkOutput("rst_wb_data", wb_data, 0);
    checkOutput("rst_wb_addr", wb_addr, 0);
    checkOutput("rst_wb_zero", wb_zero, 1);
    checkOutput("rst_retired", retired_cnt, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkRegs("rst");
    @(negedge clk);
    rst = 1'b1;

    // Single ADD with latency checks
    applyStimulus(2, 1, 0, 0, 5, 1, 1);
    idleCycle(1'b0);
    checkOutput("lat1_wb_valid", wb_valid, 0);
    idleCycle(1'b0);
    checkOutput("lat2_wb_valid", wb_valid, 1);
    checkOutput("lat2_wb_data", wb_data, 16'h0005);
    idleCycle(1'b0);
    checkOutput("first_retired", retired_cnt, 1);
    checkRegs("first");

    // Back-to-back dependencies through EX and WB forwarding
    applyStimulus(2, 1, 0, 0, 5, 1, 1);
    applyStimulus(2, 2, 1, 1, 0, 0, 1);
    applyStimulus(6, 3, 2, 1, 0, 0, 1);
    drain();
    checkRegs("fwd");

    // Wrap to zero and signed compare
    applyStimulus(2, 1, 0, 0, 16'hFFFF, 1, 1);
    applyStimulus(2, 2, 1, 0, 1, 1, 1);
    applyStimulus(7, 3, 1, 0, 1, 1, 1);
    drain();
    checkRegs("wrap");

    // Writes to r0 are discarded and never forwarded
    applyStimulus(2, 0, 0, 0, 7, 1, 1);
    applyStimulus(2, 4, 0, 0, 0, 0, 1);
    drain();
    checkRegs("r0");

    // Stall held three edges while WB holds a valid result
    savedR5 = mRegs[5];
    applyStimulus(2, 5, 0, 0, 16'h1234, 1, 1);
    idleCycle(1'b0);
    idleCycle(1'b1);
    checkOutput("stall_wb_valid0", wb_valid, 1);
    checkOutput("stall_retired0", retired_cnt, 16'(mRetired - 1));
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall_wb_valid", wb_valid, 1);
      checkOutput("stall_wb_data", wb_data, 16'h1234);
      checkOutput("stall_retired", retired_cnt, 16'(mRetired - 1));
      dbg_addr = 3'd5;
      #1;
      checkOutput("stall_r5_held", dbg_data, savedR5);
    end
    stall = 1'b0;
    @(negedge clk);
    checkOutput("unstall_retired", retired_cnt, 16'(mRetired));
    checkOutput("unstall_wb_valid", wb_valid, 0);
    checkRegs("unstall");

    // Flush (with stall also high) while two instructions are in flight
    savedRegs    = mRegs;
    savedRetired = mRetired;
    applyStimulus(2, 6, 0, 0, 16'h0BAD, 1, 1);
    applyStimulus(2, 7, 0, 0, 16'h0C0D, 1, 1);
    @(negedge clk);
    in_valid = 1'b0;
    stall    = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    stall = 1'b0;
    mRegs    = savedRegs;
    mRetired = savedRetired;
    void'(sbQueue.pop_back());
    checkOutput("flush_wb_valid", wb_valid, 0);
    checkOutput("flush_retired", retired_cnt, 16'(mRetired));
    checkRegs("flush");

    // Random stream with stall and bubble cycles between instructions
    for (int n = 0; n < 24; n++) begin
      gap = $urandom_range(0, 5);
      if (gap == 0) idleCycle(1'b1);
      else if (gap == 1) idleCycle(1'b0);
      rOp  = ops[$urandom_range(0, 7)];
      rRd  = $urandom_range(0, 7);
      rRs  = $urandom_range(0, 7);
      rRt  = $urandom_range(0, 7);
      rImm = $urandom_range(0, 65535);
      rUse = $urandom_range(0, 1);
      rWe  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      applyStimulus(rOp, rRd, rRs, rRt, rImm, rUse, rWe);
    end
    drain();
    checkRegs("rand");
    checkOutput("rand_retired", retired_cnt, 16'(mRetired));

    // Asynchronous reset mid-stream
    applyStimulus(2, 1, 0, 0, 16'h0011, 1, 1);
    applyStimulus(2, 2, 0, 0, 16'h0022, 1, 1);
    applyStimulus(2, 3, 0, 0, 16'h0033, 1, 1);
    #2;
    rst = 1'b0;
    #1;
    sbQueue.delete();
    for (int i = 0; i < REG_CNT; i++) mRegs[i] = '0;
    mRetired = 0;
    checkOutput("arst_wb_valid", wb_valid, 0);
    checkOutput("arst_wb_data", wb_data, 0);
    checkOutput("arst_wb_addr", wb_addr, 0);
    checkOutput("arst_wb_zero", wb_zero, 1);
    checkOutput("arst_retired", retired_cnt, 0);
    checkRegs("arst");

    // First edge after release accepts
    applyStimulus(2, 4, 0, 0, 16'h00A5, 1, 1);
    rst = 1'b1;
    idleCycle(1'b0);
    checkOutput("post_lat1_wb_valid", wb_valid, 0);
    idleCycle(1'b0);
    checkOutput("post_lat2_wb_valid", wb_valid, 1);
    drain();
    checkRegs("post");
    checkOutput("post_retired", retired_cnt, 16'(mRetired));

    checkOutput("sb_empty", sbQueue.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
